// File: rtl/top_keyscan.sv
// Key scanner: per-key 2-flop sync + saturating debounce; lowest eligible key commits one event per cycle into a FIFO.
// Raw edge to key_valid_o takes 3+deb_p cycles; a full FIFO holds eligible keys (stall_o) until a pop frees a slot.
module keyscan_fifo #(
  parameter int width_p = 9,
  parameter int depth_p = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [width_p-1:0] push_dat,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [width_p-1:0] head
);
  localparam int aw_p = $clog2(depth_p);

  logic [width_p-1:0] mem [depth_p];
  logic [aw_p-1:0]    rd_ptr;
  logic [aw_p-1:0]    wr_ptr;
  logic [aw_p:0]      count;
  logic               do_pop;
  logic               do_push;

  assign empty   = (count == '0);
  assign full    = (count == (aw_p+1)'(depth_p));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw_p'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw_p'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (aw_p+1)'(1);
        2'b01:   count <= count - (aw_p+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module top_keyscan #(
  parameter int keys_p  = 16,
  parameter int deb_p   = 4,
  parameter int depth_p = 4
) (
  input  logic              main_clk_i,
  input  logic              main_rst_i,
  input  logic [keys_p-1:0] raw_i,
  output logic [keys_p-1:0] level_o,
  output logic              key_valid_o,
  input  logic              key_accept_i,
  output logic [8:0]        key_data_o,
  output logic              stall_o
);
  logic [keys_p-1:0] sync1;
  logic [keys_p-1:0] sync2;
  logic [keys_p-1:0] level;
  logic [7:0]        cnt [keys_p];
  logic [keys_p-1:0] elig;
  logic [keys_p-1:0] clr;
  logic [3:0]        seq;
  logic              any_elig;
  logic [3:0]        win_idx;
  logic              win_lvl;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              commit;

  always_comb begin
    elig = '0;
    for (int k = 0; k < keys_p; k++) begin
      elig[k] = (cnt[k] == 8'(deb_p));
    end
  end

  // Descending scan so the lowest eligible index is the last assignment.
  always_comb begin
    any_elig = 1'b0;
    win_idx  = '0;
    win_lvl  = 1'b0;
    for (int k = keys_p - 1; k >= 0; k--) begin
      if (elig[k]) begin
        any_elig = 1'b1;
        win_idx  = 4'(k);
        win_lvl  = ~level[k];
      end
    end
  end

  assign pop    = key_valid_o && key_accept_i;
  assign commit = any_elig && (!fifo_full || pop);

  always_comb begin
    clr = '0;
    for (int k = 0; k < keys_p; k++) begin
      clr[k] = commit && (win_idx == 4'(k));
    end
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      seq   <= '0;
      for (int k = 0; k < keys_p; k++) cnt[k] <= '0;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
      level <= level ^ clr;
      if (commit) seq <= seq + 4'd1;
      for (int k = 0; k < keys_p; k++) begin
        if (clr[k] || (sync2[k] == level[k])) begin
          cnt[k] <= '0;
        end else if (cnt[k] != 8'(deb_p)) begin
          cnt[k] <= cnt[k] + 8'd1;
        end
      end
    end
  end

  keyscan_fifo #(
    .width_p (9),
    .depth_p (depth_p)
  ) u_fifo (
    .clk      (main_clk_i),
    .rst      (main_rst_i),
    .push     (commit),
    .push_dat ({win_lvl, win_idx, seq}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (key_data_o)
  );

  assign level_o     = level;
  assign key_valid_o = !fifo_empty;
  assign stall_o     = any_elig && !commit;
endmodule

// File: tb/tb_top_keyscan.sv
// Scoreboard bench for top_keyscan: stimulus pushes expected events, a negedge monitor compares each pop.
module tb_top_keyscan;
  localparam int keys_p  = 16;
  localparam int deb_p   = 4;
  localparam int depth_p = 4;

  logic        main_clk_i = 1'b0;
  logic        main_rst_i = 1'b1;
  logic [15:0] raw_i = '0;
  logic [15:0] level_o;
  logic        key_valid_o;
  logic        key_accept_i = 1'b0;
  logic [8:0]  key_data_o;
  logic        stall_o;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [8:0]  exp_q [$];
  int          pop_t [$];
  logic [8:0]  mon_e;

  top_keyscan #(
    .keys_p  (keys_p),
    .deb_p   (deb_p),
    .depth_p (depth_p)
  ) dut (
    .main_clk_i   (main_clk_i),
    .main_rst_i   (main_rst_i),
    .raw_i        (raw_i),
    .level_o      (level_o),
    .key_valid_o  (key_valid_o),
    .key_accept_i (key_accept_i),
    .key_data_o   (key_data_o),
    .stall_o      (stall_o)
  );

  always #5 main_clk_i = ~main_clk_i;
  always @(posedge main_clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge main_clk_i) begin
    if (!main_rst_i) begin
      if (key_valid_o && key_accept_i) begin
        pop_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event got %0h expected none", key_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("event", 32'(key_data_o), 32'(mon_e));
        end
      end else if (!key_valid_o) begin
        check("empty_data", 32'(key_data_o), 32'd0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge main_clk_i);
    #1;
  endtask

  task automatic do_reset();
    main_rst_i = 1'b1;
    exp_q.delete();
    pop_t.delete();
    step(3);
    main_rst_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid_o && n < 100) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step(1);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic accept_one();
    key_accept_i = 1'b1;
    step(1);
    key_accept_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    main_rst_i = 1'b1;
    step(3);
    check("rst_level", 32'(level_o), 0);
    check("rst_valid", 32'(key_valid_o), 0);
    check("rst_data", 32'(key_data_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    main_rst_i = 1'b0;
    step(2);

    // Single press latency and encoding
    raw_i[3] = 1'b1;
    wait_valid(n);
    check("latency", n, 3 + deb_p);
    check("press_data", 32'(key_data_o), 32'h130);
    check("press_level", 32'(level_o[3]), 1);
    check("press_stall", 32'(stall_o), 0);
    exp_q.push_back(9'h130);
    accept_one();
    check("popped_valid", 32'(key_valid_o), 0);

    // Short glitch is filtered
    raw_i[5] = 1'b1;
    step(3);
    raw_i[5] = 1'b0;
    step(12);
    check("glitch_valid", 32'(key_valid_o), 0);
    check("glitch_level", 32'(level_o), 32'h0008);

    // Simultaneous presses: lowest index first, one cycle apart
    raw_i = '0;
    do_reset();
    step(2);
    key_accept_i = 1'b1;
    exp_q.push_back(9'h120);
    exp_q.push_back(9'h191);
    raw_i[2] = 1'b1;
    raw_i[9] = 1'b1;
    wait_drain(40);
    check("pair_pops", pop_t.size(), 2);
    if (pop_t.size() == 2) check("pair_gap", pop_t[1] - pop_t[0], 1);
    key_accept_i = 1'b0;

    // Full FIFO stalls the fifth key until one pop
    raw_i = '0;
    do_reset();
    step(2);
    raw_i[4:0] = 5'h1f;
    step(12);
    check("full_stall", 32'(stall_o), 1);
    check("full_valid", 32'(key_valid_o), 1);
    check("full_head", 32'(key_data_o), 32'h100);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h111);
    exp_q.push_back(9'h122);
    exp_q.push_back(9'h133);
    exp_q.push_back(9'h144);
    accept_one();
    check("unstall", 32'(stall_o), 0);
    check("after_pop_head", 32'(key_data_o), 32'h111);
    key_accept_i = 1'b1;
    wait_drain(20);
    key_accept_i = 1'b0;
    step(1);
    check("full_drained", 32'(key_valid_o), 0);

    // Sequence wraps after 16 events
    raw_i = '0;
    do_reset();
    step(2);
    key_accept_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      raw_i[1] = ~raw_i[1];
      exp_q.push_back({raw_i[1], 4'd1, 4'(i)});
      step(12);
    end
    wait_drain(20);
    key_accept_i = 1'b0;

    // Reset mid-operation flushes the queue; held keys re-report
    raw_i = '0;
    do_reset();
    step(2);
    raw_i[2:0] = 3'b111;
    step(12);
    check("queued_valid", 32'(key_valid_o), 1);
    main_rst_i = 1'b1;
    step(1);
    check("flush_valid", 32'(key_valid_o), 0);
    check("flush_data", 32'(key_data_o), 0);
    check("flush_level", 32'(level_o), 0);
    main_rst_i = 1'b0;
    wait_valid(n);
    check("rerep_latency", n, deb_p + 3);
    check("rerep_data", 32'(key_data_o), 32'h100);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h111);
    exp_q.push_back(9'h122);
    key_accept_i = 1'b1;
    wait_drain(20);
    key_accept_i = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
